// File: rtl/sd_deadtime_bridge.sv
// Three-leg half-bridge gate driver for sigma-delta phase streams.
// Complementary gates per leg with dead-time, enable gate and latched fault.
module sd_deadtime_bridge #(
    parameter int DT_CYCLES = 8,
    parameter int CNT_BW    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic phaseA,
    input  logic phaseB,
    input  logic phaseC,
    input  logic fault_in,
    input  logic fault_clr,
    output logic gate_ah,
    output logic gate_al,
    output logic gate_bh,
    output logic gate_bl,
    output logic gate_ch,
    output logic gate_cl,
    output logic fault_latched,
    output logic running
);

    typedef enum logic [2:0] {
        OFF,
        DT_TO_HIGH,
        HIGH_ON,
        DT_TO_LOW,
        LOW_ON
    } leg_state_t;

    localparam logic [CNT_BW-1:0] DT_LOAD = CNT_BW'(DT_CYCLES - 1);

    if (DT_CYCLES < 1) begin : g_bad_dt
        $error("DT_CYCLES must be at least 1");
    end

    if (longint'(DT_CYCLES) > (longint'(1) << CNT_BW) - 1) begin : g_bad_bw
        $error("DT_CYCLES does not fit in CNT_BW bits");
    end

    logic [2:0]        demand;
    logic [2:0]        gate_h;
    logic [2:0]        gate_l;
    logic [2:0]        on_next;
    logic              fault_next;
    logic              kill;
    leg_state_t        state      [3];
    leg_state_t        state_next [3];
    logic [CNT_BW-1:0] cnt        [3];
    logic [CNT_BW-1:0] cnt_next   [3];

    // fault_in dominates fault_clr; a fresh fault kills the legs on the same edge
    assign fault_next = fault_in | (fault_latched & ~fault_clr);
    assign kill       = fault_next | ~enable;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            if (kill) begin
                state_next[i] = OFF;
            end else begin
                unique case (state[i])
                    OFF: begin
                        state_next[i] = demand[i] ? DT_TO_HIGH : DT_TO_LOW;
                    end
                    DT_TO_HIGH: begin
                        if (!demand[i])
                            state_next[i] = DT_TO_LOW;
                        else if (cnt[i] == '0)
                            state_next[i] = HIGH_ON;
                    end
                    HIGH_ON: begin
                        if (!demand[i])
                            state_next[i] = DT_TO_LOW;
                    end
                    DT_TO_LOW: begin
                        if (demand[i])
                            state_next[i] = DT_TO_HIGH;
                        else if (cnt[i] == '0)
                            state_next[i] = LOW_ON;
                    end
                    LOW_ON: begin
                        if (demand[i])
                            state_next[i] = DT_TO_HIGH;
                    end
                    default: begin
                        state_next[i] = OFF;
                    end
                endcase
            end
            // any entry into a dead-time state, including an abort, re-serves the full count
            if ((state_next[i] == DT_TO_HIGH || state_next[i] == DT_TO_LOW)
                && state_next[i] != state[i])
                cnt_next[i] = DT_LOAD;
            else if ((state[i] == DT_TO_HIGH || state[i] == DT_TO_LOW)
                     && state_next[i] == state[i])
                cnt_next[i] = cnt[i] - 1'b1;
            on_next[i] = (state_next[i] == HIGH_ON) || (state_next[i] == LOW_ON);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            demand        <= '0;
            fault_latched <= 1'b0;
            running       <= 1'b0;
            gate_h        <= '0;
            gate_l        <= '0;
            for (int i = 0; i < 3; i++) begin
                state[i] <= OFF;
                cnt[i]   <= '0;
            end
        end else begin
            demand        <= {phaseC, phaseB, phaseA};
            fault_latched <= fault_next;
            running       <= &on_next;
            for (int i = 0; i < 3; i++) begin
                state[i]  <= state_next[i];
                cnt[i]    <= cnt_next[i];
                gate_h[i] <= (state_next[i] == HIGH_ON);
                gate_l[i] <= (state_next[i] == LOW_ON);
            end
        end
    end

    assign gate_ah = gate_h[0];
    assign gate_al = gate_l[0];
    assign gate_bh = gate_h[1];
    assign gate_bl = gate_l[1];
    assign gate_ch = gate_h[2];
    assign gate_cl = gate_l[2];

endmodule
